// File: rtl/fir_mac_sequencer_if.sv
// Stream, coefficient and status signals of the time-multiplexed FIR sequencer.
// The slave modport is the sequencer's view; master is the source/sink/host side.
interface fir_mac_sequencer_if #(
    parameter int unsigned N_TAPS = 16,
    parameter int unsigned DW     = 16,
    parameter int unsigned AW     = 32
);
    localparam int unsigned AddrW = $clog2(N_TAPS);

    logic             s_valid;
    logic             s_ready;
    logic [DW-1:0]    s_data;
    logic             coef_we;
    logic [AddrW-1:0] coef_addr;
    logic [DW-1:0]    coef_data;
    logic             coef_err;
    logic             flush;
    logic             m_valid;
    logic             m_ready;
    logic [AW-1:0]    m_data;
    logic             busy;

    modport slave (
        input  s_valid, s_data, coef_we, coef_addr, coef_data, flush, m_ready,
        output s_ready, coef_err, m_valid, m_data, busy
    );

    modport master (
        output s_valid, s_data, coef_we, coef_addr, coef_data, flush, m_ready,
        input  s_ready, coef_err, m_valid, m_data, busy
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Single-multiplier FIR: one tap per cycle over a circular delay line, with
// coefficient registers, flush and valid/ready handshakes on both streams.
module fir_mac_sequencer #(
    parameter int unsigned N_TAPS = 16,
    parameter int unsigned DW     = 16,
    parameter int unsigned AW     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fir_mac_sequencer_if.slave    bus
);
    localparam int unsigned AddrW = $clog2(N_TAPS);
    typedef logic [AddrW-1:0] addr_t;
    typedef logic [AddrW:0]   addr_ext_t;
    localparam addr_t LastTap = addr_t'(N_TAPS - 1);

    typedef enum logic [1:0] {StClear, StIdle, StMac} state_e;

    state_e               state_q, state_d;
    addr_t                wptr_q, wptr_d;
    addr_t                k_q, k_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [AW-1:0]        m_data_q, m_data_d;
    logic                 m_valid_q, m_valid_d;
    logic                 coef_err_q, coef_err_d;
    logic signed [DW-1:0] coef_q [N_TAPS];
    logic signed [DW-1:0] coef_d [N_TAPS];
    logic signed [DW-1:0] dline_q [N_TAPS];
    logic signed [DW-1:0] dline_d [N_TAPS];

    addr_t                  rd_addr;
    logic signed [2*DW-1:0] prod;
    logic [AW-1:0]          prod_ext;
    logic                   s_ready;
    logic                   s_fire;
    logic                   coef_bad_addr;

    assign s_ready       = (state_q == StIdle) && (!m_valid_q || bus.m_ready);
    assign s_fire        = s_ready && bus.s_valid;
    assign coef_bad_addr = addr_ext_t'(bus.coef_addr) >= addr_ext_t'(N_TAPS);

    // Tap k reads x[n-k], stored at (wptr - k) mod N_TAPS.
    always_comb begin
        if (wptr_q >= k_q) begin
            rd_addr = wptr_q - k_q;
        end else begin
            rd_addr = addr_t'(addr_ext_t'(wptr_q) + addr_ext_t'(N_TAPS) - addr_ext_t'(k_q));
        end
        prod     = coef_q[k_q] * dline_q[rd_addr];
        prod_ext = AW'(prod);
    end

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        k_d        = k_q;
        acc_d      = acc_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q && !bus.m_ready;
        coef_err_d = 1'b0;
        coef_d     = coef_q;
        dline_d    = dline_q;

        // Rejecting writes during MAC keeps one pass on a single coefficient set.
        if (bus.coef_we) begin
            if (state_q == StMac || coef_bad_addr) begin
                coef_err_d = 1'b1;
            end else begin
                coef_d[bus.coef_addr] = bus.coef_data;
            end
        end

        unique case (state_q)
            StClear: begin
                dline_d[k_q] = '0;
                wptr_d       = '0;
                if (k_q == LastTap) begin
                    k_d     = '0;
                    state_d = StIdle;
                end else begin
                    k_d = k_q + addr_t'(1);
                end
            end
            StIdle: begin
                if (s_fire) begin
                    dline_d[wptr_q] = bus.s_data;
                    acc_d           = '0;
                    k_d             = '0;
                    state_d         = StMac;
                end else if (bus.flush) begin
                    k_d     = '0;
                    state_d = StClear;
                end
            end
            StMac: begin
                acc_d = acc_q + prod_ext;
                if (k_q == LastTap) begin
                    m_data_d  = acc_d;
                    m_valid_d = 1'b1;
                    wptr_d    = (wptr_q == LastTap) ? '0 : wptr_q + addr_t'(1);
                    k_d       = '0;
                    state_d   = StIdle;
                end else begin
                    k_d = k_q + addr_t'(1);
                end
            end
            default: begin
                k_d     = '0;
                state_d = StClear;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StClear;
            wptr_q     <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            coef_err_q <= 1'b0;
            coef_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            coef_err_q <= coef_err_d;
            coef_q     <= coef_d;
        end
    end

    // The delay line is zeroed by CLEAR, so it needs no reset.
    always_ff @(posedge clk) begin
        dline_q <= dline_d;
    end

    assign bus.s_ready  = s_ready;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_data   = m_data_q;
    assign bus.coef_err = coef_err_q;
    assign bus.busy     = (state_q != StIdle);
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer: a convolution model predicts each output
// at accept time; a separate monitor checks values and accept-to-valid latency.
module tb_fir_mac_sequencer;
    localparam int unsigned N     = 16;
    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 32;
    localparam int unsigned AddrW = $clog2(N);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_mac_sequencer_if #(.N_TAPS(N), .DW(DW), .AW(AW)) bus ();

    fir_mac_sequencer #(.N_TAPS(N), .DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int             tests = 0;
    int             fails = 0;
    int unsigned    cyc   = 0;
    logic           rand_ready = 1'b0;
    logic           mv_prev    = 1'b0;
    int             h_m [N];
    int             hist [$];
    logic [AW-1:0]  exp_q [$];
    int unsigned    lat_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got timeout/unexpected event, required normal progress", name);
    endtask

    // Reference: y[n] = sum h[k]*x[n-k] over the history since the last clear, mod 2^AW.
    task automatic record(input int x);
        longint s = 0;
        hist.push_front(x);
        if (hist.size() > N) void'(hist.pop_back());
        for (int k = 0; k < hist.size(); k++) s += longint'(h_m[k]) * longint'(hist[k]);
        exp_q.push_back(s[AW-1:0]);
        lat_q.push_back(cyc);
    endtask

    task automatic send(input int x);
        int w = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = DW'(x);
        @(negedge clk);
        while (!bus.s_ready && w < 1000) begin
            w++;
            @(negedge clk);
        end
        if (bus.s_ready) record(x);
        else fail_now("s_ready timeout");
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic rand_sample(output int x);
        logic signed [15:0] r;
        r = 16'($urandom());
        x = r;
    endtask

    task automatic write_coef(input int a, input int v);
        bus.coef_we   = 1'b1;
        bus.coef_addr = AddrW'(a);
        bus.coef_data = DW'(v);
        @(posedge clk); #1;
        bus.coef_we = 1'b0;
    endtask

    task automatic load_coefs(input int mode);
        int v;
        for (int k = 0; k < N; k++) begin
            case (mode)
                0:       v = k + 1;
                1:       v = 1;
                2:       v = -32768;
                default: rand_sample(v);
            endcase
            write_coef(k, v);
            h_m[k] = v;
        end
    endtask

    task automatic drain();
        int w = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || bus.m_valid || bus.busy) && w < 3000) begin
            w++;
            @(negedge clk);
        end
        if (w >= 3000) fail_now("drain timeout");
        @(posedge clk); #1;
    endtask

    task automatic check_clear_len(input string name);
        int e = 0;
        do begin
            @(posedge clk); #1;
            e++;
        end while (!bus.s_ready && e < 100);
        check(name, AW'(e), AW'(N));
    endtask

    task automatic check_reset_values(input string tag);
        check1({tag, " m_valid"}, bus.m_valid, 1'b0);
        check1({tag, " s_ready"}, bus.s_ready, 1'b0);
        check1({tag, " busy"}, bus.busy, 1'b1);
        check1({tag, " coef_err"}, bus.coef_err, 1'b0);
        check({tag, " m_data"}, bus.m_data, '0);
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check1("flush enters clear", bus.busy, 1'b1);
        hist.delete();
        check_clear_len("flush clear length");
    endtask

    // Monitor: latency on each m_valid rise, value on each output handshake.
    initial begin : monitor
        int unsigned t;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.m_valid && !mv_prev) begin
                    if (lat_q.size() == 0) begin
                        fail_now("unexpected m_valid");
                    end else begin
                        t = lat_q.pop_front();
                        check("latency", AW'(cyc - t), AW'(N + 1));
                    end
                end
                if (bus.m_valid && bus.m_ready) begin
                    if (exp_q.size() == 0) fail_now("unexpected output");
                    else check("y", bus.m_data, exp_q.pop_front());
                end
            end
            mv_prev = bus.m_valid;
        end
    end

    initial begin : ready_gen
        forever begin
            @(posedge clk); #1;
            if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int            x;
        int            w;
        logic [AW-1:0] held;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        bus.flush     = 1'b0;
        bus.m_ready   = 1'b1;
        for (int k = 0; k < N; k++) h_m[k] = 0;

        #3;
        check_reset_values("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_clear_len("clear length");

        // Impulse response.
        load_coefs(0);
        send(1);
        for (int i = 0; i < 16; i++) send(0);
        drain();

        // Moving sum with wptr wrapping several times.
        do_flush();
        load_coefs(1);
        for (int i = 0; i < 40; i++) send(100);
        drain();

        // Wrap arithmetic: steady state sums to 2^34 mod 2^32.
        load_coefs(2);
        for (int i = 0; i < 20; i++) send(-32768);
        drain();

        // Backpressure.
        bus.m_ready = 1'b0;
        send(1234);
        w = 0;
        @(negedge clk);
        while (!bus.m_valid && w < 100) begin
            w++;
            @(negedge clk);
        end
        check1("bp m_valid", bus.m_valid, 1'b1);
        held = bus.m_data;
        @(posedge clk); #1;
        bus.s_valid = 1'b1;
        bus.s_data  = DW'(-77);
        repeat (40) begin
            @(negedge clk);
            check1("bp s_ready low", bus.s_ready, 1'b0);
            check("bp m_data held", bus.m_data, held);
            @(posedge clk); #1;
        end
        bus.m_ready = 1'b1;
        @(negedge clk);
        check1("bp accept on m_ready", bus.s_ready, 1'b1);
        if (bus.s_ready) record(-77);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        drain();

        // Coefficient protection: rejected in MAC, accepted in IDLE.
        load_coefs(0);
        send(3);
        write_coef(3, 7);
        check1("coef_err pulse", bus.coef_err, 1'b1);
        @(posedge clk); #1;
        check1("coef_err one cycle", bus.coef_err, 1'b0);
        for (int i = 0; i < 4; i++) send(i * 11 - 5);
        drain();
        write_coef(3, 7);
        check1("coef_err idle write", bus.coef_err, 1'b0);
        h_m[3] = 7;
        @(posedge clk); #1;
        check1("coef_err idle next", bus.coef_err, 1'b0);
        for (int i = 0; i < 6; i++) begin
            rand_sample(x);
            send(x);
        end
        drain();

        // Randomized traffic with random backpressure and gaps.
        load_coefs(3);
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rand_sample(x);
            send(x);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end
        rand_ready  = 1'b0;
        bus.m_ready = 1'b1;
        drain();

        // Reset during MAC tap 5, then impulse with zero history.
        load_coefs(0);
        send(9);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid-mac reset");
        exp_q.delete();
        lat_q.delete();
        hist.delete();
        for (int k = 0; k < N; k++) h_m[k] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        check_clear_len("reclear length");
        load_coefs(0);
        send(1);
        for (int i = 0; i < 16; i++) send(0);
        drain();

        // Flush in IDLE: later outputs see only new samples.
        load_coefs(3);
        for (int i = 0; i < 5; i++) begin
            rand_sample(x);
            send(x);
        end
        drain();
        do_flush();
        for (int i = 0; i < 5; i++) begin
            rand_sample(x);
            send(x);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
